// File: rtl/zz_scan_pkg.sv
// Shared types and helpers for the zig-zag scan address generator.
package zz_scan_pkg;

  localparam int MAX_LOG2N_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // UP moves toward row 0 (up-right); DOWN moves toward col 0 (down-left).
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  // Keep the block side inside 2..2**max_l2 so the walk never degenerates
  // and never exceeds the index counter width.
  function automatic logic [2:0] clamp_log2n(input logic [2:0] l2, input int max_l2);
    if (l2 == 3'd0) begin
      return 3'd1;
    end else if (int'(l2) > max_l2) begin
      return 3'(max_l2);
    end else begin
      return l2;
    end
  endfunction

endpackage

// File: rtl/zz_walk_step.sv
// One step of the JPEG zig-zag walk: given the current (row, col, direction)
// and the last valid row/col index, produce the next position and direction.
module zz_walk_step
  import zz_scan_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] ri_i,
  input  logic [W-1:0] ci_i,
  input  dir_t         dir_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] ri_o,
  output logic [W-1:0] ci_o,
  output dir_t         dir_o
);

  // Edge cases first: hitting the right/bottom edge wins over the top/left edge,
  // which is what turns the corner correctly on the anti-diagonal.
  always_comb begin
    ri_o  = ri_i;
    ci_o  = ci_i;
    dir_o = dir_i;
    if (dir_i == UP) begin
      if (ci_i == max_i) begin
        ri_o  = ri_i + 1'b1;
        dir_o = DOWN;
      end else if (ri_i == '0) begin
        ci_o  = ci_i + 1'b1;
        dir_o = DOWN;
      end else begin
        ri_o = ri_i - 1'b1;
        ci_o = ci_i + 1'b1;
      end
    end else begin
      if (ri_i == max_i) begin
        ci_o  = ci_i + 1'b1;
        dir_o = UP;
      end else if (ci_i == '0) begin
        ri_o  = ri_i + 1'b1;
        dir_o = UP;
      end else begin
        ri_o = ri_i + 1'b1;
        ci_o = ci_i - 1'b1;
      end
    end
  end

endmodule

// File: rtl/zz_scan_gen.sv
// Parametrised zig-zag scan address generator. Streams (row,col) addresses of
// an N x N block in JPEG order, optionally transposed, over one or more blocks.
//
// Handshake: out_valid/out_* are registered and stay stable while
// out_valid && !out_ready; an element transfers on a rising edge where
// out_valid && out_ready. out_valid never drops inside a run except on abort.
module zz_scan_gen
  import zz_scan_pkg::*;
#(
  parameter int MAX_LOG2N = MAX_LOG2N_DEF,
  parameter int BLK_W     = 8
) (
  input  logic                   Clock_50,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2:0]             log2n,
  input  logic                   transpose,
  input  logic [BLK_W-1:0]       num_blocks,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*MAX_LOG2N-1:0] out_addr,
  output logic [2*MAX_LOG2N-1:0] out_idx,
  output logic [BLK_W-1:0]       out_blk,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   done,
  output state_t                 dbg_state
);

  localparam int RW    = MAX_LOG2N;
  localparam int IDX_W = 2 * MAX_LOG2N;

  state_t           state_q, state_d;
  logic [2:0]       log2n_q, log2n_d;
  logic             tr_q, tr_d;
  logic [BLK_W-1:0] last_blk_q, last_blk_d;
  logic [RW-1:0]    ri_q, ri_d, ci_q, ci_d;
  dir_t             dir_q, dir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             done_q, done_d;

  logic [RW:0]      side;
  logic [RW-1:0]    max_rc;
  logic [IDX_W:0]   area;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] ri_ext, ci_ext;
  logic [RW-1:0]    ri_step, ci_step;
  dir_t             dir_step;
  logic             at_last;

  // Block geometry from the latched exponent: max index per axis and last zig-zag index.
  always_comb begin
    side     = {{RW{1'b0}}, 1'b1} << log2n_q;
    max_rc   = side[RW-1:0] - 1'b1;
    area     = {{IDX_W{1'b0}}, 1'b1} << {log2n_q, 1'b0};
    last_idx = area[IDX_W-1:0] - 1'b1;
    at_last  = (idx_q == last_idx);
  end

  zz_walk_step #(.W(RW)) u_step (
    .ri_i  (ri_q),
    .ci_i  (ci_q),
    .dir_i (dir_q),
    .max_i (max_rc),
    .ri_o  (ri_step),
    .ci_o  (ci_step),
    .dir_o (dir_step)
  );

  // Next-state: abort beats everything; start only matters in IDLE.
  always_comb begin
    state_d    = state_q;
    log2n_d    = log2n_q;
    tr_d       = tr_q;
    last_blk_d = last_blk_q;
    ri_d       = ri_q;
    ci_d       = ci_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    blk_d      = blk_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = SCAN;
            log2n_d    = clamp_log2n(log2n, MAX_LOG2N);
            tr_d       = transpose;
            last_blk_d = (num_blocks == '0) ? '0 : num_blocks - 1'b1;
            ri_d       = '0;
            ci_d       = '0;
            dir_d      = UP;
            idx_d      = '0;
            blk_d      = '0;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (at_last) begin
              if (blk_q < last_blk_q) begin
                // Roll straight into the next block without a bubble.
                blk_d = blk_q + 1'b1;
                ri_d  = '0;
                ci_d  = '0;
                dir_d = UP;
                idx_d = '0;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              ri_d  = ri_step;
              ci_d  = ci_step;
              dir_d = dir_step;
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      log2n_q    <= 3'd1;
      tr_q       <= 1'b0;
      last_blk_q <= '0;
      ri_q       <= '0;
      ci_q       <= '0;
      dir_q      <= UP;
      idx_q      <= '0;
      blk_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      log2n_q    <= log2n_d;
      tr_q       <= tr_d;
      last_blk_q <= last_blk_d;
      ri_q       <= ri_d;
      ci_q       <= ci_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      blk_q      <= blk_d;
      done_q     <= done_d;
    end
  end

  // Outputs: address is a shift-and-or of the registered position, flags follow state.
  always_comb begin
    ri_ext    = {{(IDX_W-RW){1'b0}}, ri_q};
    ci_ext    = {{(IDX_W-RW){1'b0}}, ci_q};
    out_addr  = tr_q ? ((ci_ext << log2n_q) | ri_ext) : ((ri_ext << log2n_q) | ci_ext);
    out_valid = (state_q == SCAN);
    busy      = (state_q == SCAN);
    out_idx   = idx_q;
    out_blk   = blk_q;
    out_first = out_valid && (idx_q == '0);
    out_last  = out_valid && at_last;
    done      = done_q;
    dbg_state = state_q;
  end

endmodule
